// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. Each bit is held for Prescale clocks.
// A Prescale value of 0 is treated as 1. TX_OUT and Busy are registered.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state, state_nxt;
  logic [5:0]              cnt, cnt_nxt;
  logic [5:0]              p_last_q, p_last_nxt;   // captured bit length minus one
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [DATA_WIDTH-1:0]   data_q, data_nxt;
  logic                    par_en_q, par_en_nxt;
  logic                    par_bit_q, par_bit_nxt;
  logic                    tx_nxt, busy_nxt;
  logic                    bit_done;

  // Last cycle of the current bit period.
  assign bit_done = (cnt == p_last_q);

  // Next-state, counters, capture and next registered outputs.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    data_nxt    = data_q;
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit_q;
    p_last_nxt  = p_last_q;
    tx_nxt      = TX_OUT;
    busy_nxt    = Busy;

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (Data_Valid) begin
          state_nxt   = START;
          data_nxt    = P_DATA;
          par_en_nxt  = PAR_EN;
          // Even parity is the XOR of the data; odd parity is its inverse.
          par_bit_nxt = (^P_DATA) ^ PAR_TYP;
          p_last_nxt  = (Prescale == 6'd0) ? 6'd0 : (Prescale - 6'd1);
          cnt_nxt     = 6'd0;
          idx_nxt     = '0;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          cnt_nxt   = 6'd0;
          idx_nxt   = '0;
          tx_nxt    = data_q[0];
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_nxt = 6'd0;
          if (idx == LAST_IDX) begin
            if (par_en_q) begin
              state_nxt = PARITY;
              tx_nxt    = par_bit_q;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            idx_nxt = idx + 1'b1;
            tx_nxt  = data_q[idx_nxt];
          end
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end

      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          cnt_nxt   = 6'd0;
          tx_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end

      STOP: begin
        // Returning to IDLE here (without looking at Data_Valid) guarantees
        // at least one idle cycle between frames.
        if (bit_done) begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 6'd0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters, captured frame settings and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      idx       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      p_last_q  <= 6'd0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      data_q    <= data_nxt;
      par_en_q  <= par_en_nxt;
      par_bit_q <= par_bit_nxt;
      p_last_q  <= p_last_nxt;
      TX_OUT    <= tx_nxt;
      Busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer (DATA_WIDTH = 8).
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  // Hand-derived line sequence for 8'hA5 without parity.
  logic [0:9] exp_a5 = 10'b0101001011;

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  // Advance past one rising edge and settle; outputs are sampled here and
  // inputs are changed here, well away from the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge. Walks the whole frame checking
  // TX_OUT and Busy on every cycle, then checks the idle state after it.
  // With meddle set, inputs are disturbed during data bit 3.
  task automatic check_frame(input string name, input logic [7:0] d,
                             input logic pe, input logic pb, input int p,
                             input bit meddle);
    int   nbits;
    logic e;
    nbits = pe ? 11 : 10;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                 e = 1'b0;
      else if (b <= 8)            e = d[b-1];
      else if (pe && b == 9)      e = pb;
      else                        e = 1'b1;
      for (int c = 0; c < p; c++) begin
        chk($sformatf("%s tx bit%0d cyc%0d", name, b, c), TX_OUT, e);
        chk($sformatf("%s busy bit%0d cyc%0d", name, b, c), Busy, 1'b1);
        if (meddle && b == 3 && c == 0) begin
          Data_Valid = 1'b1;
          P_DATA     = 8'hFF;
          PAR_EN     = 1'b1;
          PAR_TYP    = 1'b1;
          Prescale   = 6'd5;
        end
        if (meddle && b == 3 && c == 1) Data_Valid = 1'b0;
        tick();
      end
    end
    chk({name, " end busy"}, Busy, 1'b0);
    chk({name, " end tx"}, TX_OUT, 1'b1);
  endtask

  initial begin
    RST        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd1;

    // Reset held with a pending request: line stays idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst tx %0d", i), TX_OUT, 1'b1);
      chk($sformatf("rst busy %0d", i), Busy, 1'b0);
    end
    RST        = 1'b1;
    Data_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post-rst tx %0d", i), TX_OUT, 1'b1);
      chk($sformatf("post-rst busy %0d", i), Busy, 1'b0);
    end

    // 8'hA5, no parity, one cycle per bit.
    P_DATA = 8'hA5; PAR_EN = 1'b0; Prescale = 6'd1; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5 tx %0d", i), TX_OUT, exp_a5[i]);
      chk($sformatf("a5 busy %0d", i), Busy, 1'b1);
      tick();
    end
    chk("a5 end busy", Busy, 1'b0);
    chk("a5 end tx", TX_OUT, 1'b1);
    tick();

    // 8'h07 with even parity (bit 1), eight cycles per bit.
    P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    check_frame("07even", 8'h07, 1'b1, 1'b1, 8, 1'b0);
    tick();

    // 8'h07 with odd parity (bit 0).
    P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd8; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    check_frame("07odd", 8'h07, 1'b1, 1'b0, 8, 1'b0);
    tick();

    // 8'h3C, inputs disturbed mid-frame must not alter the frame.
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd2; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    check_frame("3Cheld", 8'h3C, 1'b0, 1'b0, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("no-ff tx %0d", i), TX_OUT, 1'b1);
      chk($sformatf("no-ff busy %0d", i), Busy, 1'b0);
    end

    // Reset during data bit 3 of 8'hF0 (bit 3 is 0), Prescale 4.
    P_DATA = 8'hF0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    chk("bit3 tx", TX_OUT, 1'b0);
    chk("bit3 busy", Busy, 1'b1);
    RST = 1'b0;
    tick();
    chk("midrst tx", TX_OUT, 1'b1);
    chk("midrst busy", Busy, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("after midrst tx %0d", i), TX_OUT, 1'b1);
      chk($sformatf("after midrst busy %0d", i), Busy, 1'b0);
    end
    P_DATA = 8'h81; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    check_frame("81clean", 8'h81, 1'b0, 1'b0, 4, 1'b0);
    tick();

    // Prescale 0 acts as 1; Data_Valid held high gives one idle cycle gaps.
    P_DATA = 8'h96; PAR_EN = 1'b0; Prescale = 6'd0; Data_Valid = 1'b1;
    tick();
    check_frame("96a", 8'h96, 1'b0, 1'b0, 1, 1'b0);
    tick();
    check_frame("96b", 8'h96, 1'b0, 1'b0, 1, 1'b0);
    tick();
    Data_Valid = 1'b0;
    check_frame("96c", 8'h96, 1'b0, 1'b0, 1, 1'b0);
    tick();
    chk("final idle tx", TX_OUT, 1'b1);
    chk("final idle busy", Busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
